// File: rtl/timer_arbiter_if.sv
// ---------------------------------------------------------------------------
// timer_arbiter_if
// Bundles the requester handshake and the flex_counter control lines shared
// by timer_arbiter and its surroundings.
//
// Signals:
//   req               requester -> arbiter, level request per requester
//   req_len           requester -> arbiter, interval length, slice [i*SIZE +: SIZE]
//   grant             arbiter -> requester, one-hot owner of the counter
//   done              arbiter -> requester, one-cycle completion pulse
//   busy              arbiter -> requester, high whenever not idle
//   cnt_clear         arbiter -> flex_counter clear
//   cnt_enable        arbiter -> flex_counter count_enable
//   cnt_rollover_val  arbiter -> flex_counter rollover_val
//   cnt_rollover_flag flex_counter -> arbiter rollover_flag
//
// Modports:
//   slave  - the arbiter side
//   master - the requesters / counter side that drives the arbiter
// ---------------------------------------------------------------------------
interface timer_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int SIZE    = 4
);
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ*SIZE-1:0] req_len;
    logic [NUM_REQ-1:0]      grant;
    logic [NUM_REQ-1:0]      done;
    logic                    busy;
    logic                    cnt_clear;
    logic                    cnt_enable;
    logic [SIZE-1:0]         cnt_rollover_val;
    logic                    cnt_rollover_flag;

    modport slave (
        input  req, req_len, cnt_rollover_flag,
        output grant, done, busy, cnt_clear, cnt_enable, cnt_rollover_val
    );

    modport master (
        output req, req_len, cnt_rollover_flag,
        input  grant, done, busy, cnt_clear, cnt_enable, cnt_rollover_val
    );
endinterface

// File: rtl/timer_arbiter.sv
// ---------------------------------------------------------------------------
// timer_arbiter
// Shares one external flex_counter among NUM_REQ requesters. Pending requests
// are arbitrated round-robin; the winner's length is loaded into the counter's
// rollover_val, the counter is enabled until rollover_flag rises, and the
// winner then receives a one-cycle done pulse before the counter is cleared.
// Dropping the owner's request before completion abandons the interval.
//
// Ports:
//   clk    input  system clock, rising edge
//   n_rst  input  asynchronous active-low reset
//   bus    timer_arbiter_if.slave  requester handshake and counter control
// ---------------------------------------------------------------------------
module timer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SIZE    = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    timer_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    winner;
    logic [IDX_W-1:0]    pick;
    logic                pick_valid;
    logic [SIZE-1:0]     pick_len;
    logic [NUM_REQ-1:0]  grant_q;
    logic [SIZE-1:0]     rollover_q;
    logic                owner_req;

    logic [NUM_REQ-1:0]  done_c;
    logic                busy_c;
    logic                clear_c;
    logic                enable_c;

    // Index arithmetic modulo NUM_REQ, kept in index width.
    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'(v % NUM_REQ);
    endfunction

    // Round-robin search starting at ptr. Iterating from the farthest offset
    // down to zero lets the closest set bit overwrite earlier candidates.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[wrap_idx(int'(ptr) + k)]) begin
                pick       = wrap_idx(int'(ptr) + k);
                pick_valid = 1'b1;
            end
        end
    end

    // Length of the candidate winner, selected with constant slices only.
    always_comb begin
        pick_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                pick_len = bus.req_len[i*SIZE +: SIZE];
            end
        end
    end

    assign owner_req = bus.req[winner];

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and counter-control decode. An owner that drops its request
    // during LOAD or RUN aborts back to IDLE, which also clears the counter.
    // Enable follows the flag combinationally so the counter stops on the
    // very cycle it reaches rollover_val and never wraps.
    always_comb begin
        next_state = state;
        done_c     = '0;
        busy_c     = 1'b1;
        clear_c    = 1'b0;
        enable_c   = 1'b0;
        case (state)
            IDLE: begin
                busy_c  = 1'b0;
                clear_c = 1'b1;
                if (pick_valid) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (!owner_req) begin
                    next_state = IDLE;
                end else if (rollover_q == '0) begin
                    next_state = DONE;
                end else begin
                    next_state = RUN;
                end
            end
            RUN: begin
                enable_c = ~bus.cnt_rollover_flag;
                if (!owner_req) begin
                    next_state = IDLE;
                end else if (bus.cnt_rollover_flag) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                clear_c    = 1'b1;
                done_c     = grant_q;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Grant, latched winner/length and round-robin pointer. The pointer only
    // advances after a completed interval, so an aborted owner keeps its turn.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr        <= '0;
            winner     <= '0;
            grant_q    <= '0;
            rollover_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        winner     <= pick;
                        grant_q    <= NUM_REQ'(1) << pick;
                        rollover_q <= pick_len;
                    end
                end
                LOAD, RUN: begin
                    if (next_state == IDLE) begin
                        grant_q <= '0;
                    end
                end
                DONE: begin
                    grant_q <= '0;
                    ptr     <= wrap_idx(int'(winner) + 1);
                end
                default: begin
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant            = grant_q;
    assign bus.done             = done_c;
    assign bus.busy             = busy_c;
    assign bus.cnt_clear        = clear_c;
    assign bus.cnt_enable       = enable_c;
    assign bus.cnt_rollover_val = rollover_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_timer_arbiter
// Self-checking bench for timer_arbiter. Contains a behavioural flex_counter
// attached to the counter control lines, a done-pulse scoreboard fed by the
// scenario tasks, and a per-cycle invariant monitor.
// ---------------------------------------------------------------------------
module tb_timer_arbiter;
    localparam int NUM_REQ = 4;
    localparam int SIZE    = 4;

    typedef struct {
        logic [NUM_REQ-1:0] vec;
        int                 cyc;
    } exp_t;

    logic clk;
    logic n_rst;
    int   cyc;
    int   total;
    int   bad;
    exp_t sb[$];

    logic [SIZE-1:0] cnt_count;
    logic [SIZE-1:0] cnt_next;
    logic            cnt_flag;

    timer_arbiter_if #(.NUM_REQ(NUM_REQ), .SIZE(SIZE)) bus ();

    timer_arbiter #(.NUM_REQ(NUM_REQ), .SIZE(SIZE)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural flex_counter: rolls over to 1 after reaching rollover_val,
    // flag registered high while count equals rollover_val.
    assign cnt_next = (cnt_count == bus.cnt_rollover_val) ? SIZE'(1) : cnt_count + SIZE'(1);
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_count <= '0;
            cnt_flag  <= 1'b0;
        end else if (bus.cnt_clear) begin
            cnt_count <= '0;
            cnt_flag  <= 1'b0;
        end else if (bus.cnt_enable) begin
            cnt_count <= cnt_next;
            cnt_flag  <= (cnt_next == bus.cnt_rollover_val);
        end
    end
    assign bus.cnt_rollover_flag = cnt_flag;

    // Done scoreboard and invariants, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done !== '0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_done got=%b want=none cyc=%0d", bus.done, cyc);
            end else begin
                e = sb.pop_front();
                if (bus.done !== e.vec || cyc != e.cyc) begin
                    bad++;
                    $display("[TB] FAIL done_pulse got=%b@%0d want=%b@%0d", bus.done, cyc, e.vec, e.cyc);
                end
            end
        end
        total++;
        if (!$onehot0(bus.grant) || ((bus.done & ~bus.grant) !== '0)
            || (bus.cnt_enable && bus.cnt_clear)) begin
            bad++;
            $display("[TB] FAIL invariant grant=%b done=%b en=%b clr=%b", bus.grant, bus.done,
                     bus.cnt_enable, bus.cnt_clear);
        end
    end

    task automatic push_exp(input logic [NUM_REQ-1:0] vec, input int at);
        exp_t e;
        e.vec = vec;
        e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        bus.req     = '0;
        bus.req_len = '0;
        n_rst       = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.cnt_clear !== 1'b1 ||
            bus.cnt_enable !== 1'b0 || bus.done !== '0 || bus.cnt_rollover_val !== '0) begin
            bad++;
            $display("[TB] FAIL reset_values got g=%b b=%b c=%b e=%b rv=%0d want g=0 b=0 c=1 e=0 rv=0",
                     bus.grant, bus.busy, bus.cnt_clear, bus.cnt_enable, bus.cnt_rollover_val);
        end
        n_rst = 1'b1;
        @(negedge clk);
        bus.req_len[3:0] = 4'd5;
        bus.req          = 4'b0001;
        for (int k = 0; k <= 2; k++) @(negedge clk);
        total++;
        if (bus.busy !== 1'b1 || bus.cnt_enable !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_prerun got b=%b e=%b want b=1 e=1", bus.busy, bus.cnt_enable);
        end
        n_rst = 1'b0;
        #1;
        total++;
        if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.cnt_clear !== 1'b1 || bus.cnt_enable !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_midrun got g=%b b=%b c=%b e=%b want g=0 b=0 c=1 e=0",
                     bus.grant, bus.busy, bus.cnt_clear, bus.cnt_enable);
        end
        @(negedge clk);
        bus.req = '0;
        n_rst   = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.grant !== '0) begin
            bad++;
            $display("[TB] FAIL reset_idle got b=%b g=%b want b=0 g=0", bus.busy, bus.grant);
        end
    endtask

    task automatic test_single;
        int e0;
        int en_cnt;
        en_cnt = 0;
        bus.req_len[3:0] = 4'd3;
        bus.req          = 4'b0001;
        e0 = cyc + 1;
        push_exp(4'b0001, e0 + 5);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (bus.cnt_enable) en_cnt++;
            if (k == 0) begin
                total++;
                if (bus.grant !== 4'b0001 || bus.cnt_rollover_val !== 4'd3) begin
                    bad++;
                    $display("[TB] FAIL single_grant got g=%b rv=%0d want g=0001 rv=3", bus.grant, bus.cnt_rollover_val);
                end
            end
            if (k == 1) bus.req_len[3:0] = 4'd7;
            if (k == 4) begin
                total++;
                if (cnt_count !== 4'd3 || cnt_flag !== 1'b1 || bus.cnt_rollover_val !== 4'd3) begin
                    bad++;
                    $display("[TB] FAIL single_count got cnt=%0d flag=%b rv=%0d want 3 1 3", cnt_count, cnt_flag, bus.cnt_rollover_val);
                end
            end
            if (k == 5) bus.req = '0;
            if (k == 6) begin
                total++;
                if (bus.busy !== 1'b0 || bus.grant !== '0) begin
                    bad++;
                    $display("[TB] FAIL single_release got b=%b g=%b want b=0 g=0", bus.busy, bus.grant);
                end
            end
        end
        total++;
        if (en_cnt != 3) begin
            bad++;
            $display("[TB] FAIL single_enables got=%0d want=3", en_cnt);
        end
    endtask

    task automatic test_round_robin;
        int e0;
        logic [NUM_REQ-1:0] order [4];
        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b1000;
        order[3] = 4'b0001;
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        bus.req_len = 16'h1111;
        bus.req     = 4'b1011;
        e0 = cyc + 1;
        for (int i = 0; i < 4; i++) push_exp(order[i], e0 + 5*i + 3);
        for (int k = 0; k <= 19; k++) begin
            @(negedge clk);
            if (k % 5 == 0 && k < 20) begin
                total++;
                if (bus.grant !== order[k/5]) begin
                    bad++;
                    $display("[TB] FAIL rr_grant%0d got=%b want=%b", k/5, bus.grant, order[k/5]);
                end
            end
            if (k == 18) bus.req = '0;
        end
        total++;
        if (bus.grant !== '0 || bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rr_idle got g=%b b=%b want g=0 b=0", bus.grant, bus.busy);
        end
    endtask

    task automatic test_zero_len;
        int e0;
        int en_cnt;
        en_cnt = 0;
        bus.req_len[11:8] = 4'd0;
        bus.req           = 4'b0100;
        e0 = cyc + 1;
        push_exp(4'b0100, e0 + 1);
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (bus.cnt_enable) en_cnt++;
            if (k == 0) begin
                total++;
                if (bus.grant !== 4'b0100) begin
                    bad++;
                    $display("[TB] FAIL zero_grant got=%b want=0100", bus.grant);
                end
            end
            if (k == 1) bus.req = '0;
            if (k == 2) begin
                total++;
                if (bus.busy !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL zero_busy got=%b want=0", bus.busy);
                end
            end
        end
        total++;
        if (en_cnt != 0) begin
            bad++;
            $display("[TB] FAIL zero_enables got=%0d want=0", en_cnt);
        end
    endtask

    task automatic test_abort;
        int e0;
        bus.req_len[7:4] = 4'd5;
        bus.req          = 4'b0010;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                total++;
                if (bus.grant !== 4'b0010) begin
                    bad++;
                    $display("[TB] FAIL abort_grant got=%b want=0010", bus.grant);
                end
            end
            if (k == 3) begin
                total++;
                if (cnt_count !== 4'd2) begin
                    bad++;
                    $display("[TB] FAIL abort_precount got=%0d want=2", cnt_count);
                end
                bus.req = '0;
            end
            if (k == 4) begin
                total++;
                if (bus.busy !== 1'b0 || bus.grant !== '0 || bus.cnt_clear !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL abort_idle got b=%b g=%b c=%b want b=0 g=0 c=1", bus.busy, bus.grant, bus.cnt_clear);
                end
            end
            if (k == 5) begin
                total++;
                if (cnt_count !== 4'd0) begin
                    bad++;
                    $display("[TB] FAIL abort_cleared got=%0d want=0", cnt_count);
                end
            end
        end
        bus.req_len[3:0]  = 4'd2;
        bus.req_len[11:8] = 4'd2;
        bus.req           = 4'b0101;
        e0 = cyc + 1;
        push_exp(4'b0001, e0 + 4);
        push_exp(4'b0100, e0 + 10);
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k == 0) begin
                total++;
                if (bus.grant !== 4'b0001) begin
                    bad++;
                    $display("[TB] FAIL abort_next_grant got=%b want=0001", bus.grant);
                end
            end
            if (k == 4) bus.req = 4'b0100;
            if (k == 6) begin
                total++;
                if (bus.grant !== 4'b0100) begin
                    bad++;
                    $display("[TB] FAIL abort_second_grant got=%b want=0100", bus.grant);
                end
            end
            if (k == 10) bus.req = '0;
        end
    endtask

    task automatic test_max_len;
        int e0;
        int en_cnt;
        en_cnt = 0;
        bus.req_len[15:12] = 4'd15;
        bus.req            = 4'b1000;
        e0 = cyc + 1;
        push_exp(4'b1000, e0 + 17);
        for (int k = 0; k <= 18; k++) begin
            @(negedge clk);
            if (bus.cnt_enable) en_cnt++;
            if (k == 16) begin
                total++;
                if (cnt_count !== 4'd15 || cnt_flag !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL max_count got cnt=%0d flag=%b want 15 1", cnt_count, cnt_flag);
                end
            end
            if (k == 17) begin
                total++;
                if (cnt_count !== 4'd15) begin
                    bad++;
                    $display("[TB] FAIL max_nowrap got=%0d want=15", cnt_count);
                end
                bus.req = '0;
            end
        end
        total++;
        if (en_cnt != 15) begin
            bad++;
            $display("[TB] FAIL max_enables got=%0d want=15", en_cnt);
        end
    endtask

    initial begin
        cyc   = 0;
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_abort();
        test_max_len();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
Controller that shares one flex_counter instance among NUM_REQ requesters that each need a timed interval.
- Arbitrates pending requests round-robin.
- Programs the counter's rollover_val, enables counting, and watches rollover_flag.
- Returns a one-cycle done pulse to the granted requester, then clears the counter.
- Drives the counter's clear/count_enable/rollover_val ports directly; the counter instance is outside this block.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
SIZE, 4, counter width; must equal the attached flex_counter's width

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
req  input  NUM_REQ  level request per requester; hold high until done
req_len  input  NUM_REQ*SIZE  interval length for requester i, in slice [i*SIZE +: SIZE]
grant  output  NUM_REQ  one-hot, registered; current owner of the counter
done  output  NUM_REQ  one-cycle pulse to the owner when its interval completes
busy  output  1  high whenever state != IDLE
cnt_clear  output  1  to flex_counter clear
cnt_enable  output  1  to flex_counter count_enable
cnt_rollover_val  output  SIZE  to flex_counter rollover_val, registered
cnt_rollover_flag  input  1  from flex_counter rollover_flag

Behaviour:
Clock and reset: one clock clk; reset n_rst is asynchronous, active-low.

Reset values (also on reset mid-operation):
- state=IDLE, grant=0, done=0, busy=0, cnt_enable=0, cnt_clear=1, cnt_rollover_val=0.
- Round-robin pointer ptr=0; in-flight interval abandoned with no done pulse.

States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cnt_clear=1, cnt_enable=0.
  - If any req bit set at the edge: winner = first set bit searching ptr, ptr+1, ... (mod NUM_REQ).
  - Latch winner index, grant=onehot(winner), cnt_rollover_val=req_len[winner] -> LOAD.
- LOAD:
  - One cycle with cnt_clear=0, cnt_enable=0 so rollover_val settles.
  - Latched length 0 -> DONE (no counting).
  - Else -> RUN.
- RUN:
  - cnt_enable = ~cnt_rollover_flag (combinational), cnt_clear=0.
  - When cnt_rollover_flag=1 -> DONE. Enable is already low that cycle, so the counter never wraps.
- DONE:
  - done[winner]=1 for exactly this cycle, cnt_clear=1, cnt_enable=0.
  - ptr=winner+1 mod NUM_REQ -> IDLE; grant drops to 0 on that edge.

Timing for length N>=1, req sampled at edge E0:
- grant high after E0.
- Counter enabled across edges E2..E(N+1); flag high after E(N+1).
- done pulse in the cycle after E(N+2).
- grant=0 and busy=0 after E(N+3).
- Length 0: done in the cycle after E1.

Abort:
- If req[winner] is low in LOAD or RUN, go to IDLE on the next edge: no done pulse, counter cleared, ptr unchanged.

Arbitration rules:
- Requests arriving while busy wait; no preemption.
- A requester holding req high after done is re-arbitrated normally. The pointer has moved past it, so other pending requesters go first.
- req_len is sampled only in IDLE; later changes are ignored.

Invariants:
- grant is one-hot or zero.
- done is a subset of grant.
- cnt_enable and cnt_clear are never both 1.

Test Plan:
1. Reset: assert n_rst=0 mid-RUN -> grant=0, busy=0, cnt_clear=1, cnt_enable=0 immediately; after release, idle with no done.
2. Single request: req=0001, req_len[0]=3 -> grant=0001 after E0; cnt_enable high exactly 3 cycles; attached counter reaches 3 with flag=1; done=0001 one cycle after E5; busy=0 after E6.
3. Round robin: req=1011 held high, all lengths 1 -> grant order 0001, 0010, 1000, 0001; each done pulses once per grant.
4. Zero length: req=0100, req_len[2]=0 -> cnt_enable never asserts; done=0100 one cycle after E1.
5. Abort: req=0010, req_len[1]=5; drop req[1] after 2 enabled cycles -> IDLE next edge, no done, counter cleared to 0; then req=0001 is served next.
6. Max length: req_len=15 with SIZE=4 -> exactly 15 enabled cycles; count_out=15, never wraps to 1 before clear.
